// File: rtl/mux2_to_1_pkg.sv
// Shared datapath constants for the MIPS operand steering muxes.
// Holds the native word width and the select-line encoding.
package mux2_to_1_pkg;

    localparam int WORD_WIDTH = 32;

    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;

endpackage

// File: rtl/mux2_comb.sv
// Parameterized purely combinational 2:1 word selector.
// An unknown select yields an all-X word instead of favouring either input.
module mux2_comb
    import mux2_to_1_pkg::*;
#(
    parameter int WIDTH = WORD_WIDTH
) (
    input  logic [WIDTH-1:0] in1_i,
    input  logic [WIDTH-1:0] in2_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] out_o
);

    // A case with an X default avoids the bitwise merge that ?: would give on an unknown sel.
    always_comb begin
        out_o = 'x;
        case (sel_i)
            SEL_IN1: out_o = in1_i;
            SEL_IN2: out_o = in2_i;
            default: out_o = 'x;
        endcase
    end

endmodule

// File: rtl/mux2_to_1.sv
// Clocked 2:1 word mux: zero-latency combinational output plus a registered copy
// carrying the captured select, a valid flag and a select-change pulse.
module mux2_to_1
    import mux2_to_1_pkg::*;
#(
    parameter int              WIDTH     = WORD_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] output1,
    output logic [WIDTH-1:0] output1_q,
    output logic             sel_q,
    output logic             valid_q,
    output logic             sel_changed
);

    logic [WIDTH-1:0] muxOut;

    logic [WIDTH-1:0] loadData_d, loadData_q;
    logic             loadSel_d, loadSel_q;
    logic             loadValid_d, loadValid_q;
    logic             selChanged_d, selChanged_q;

    mux2_comb #(
        .WIDTH(WIDTH)
    ) u_mux2_comb (
        .in1_i(input1),
        .in2_i(input2),
        .sel_i(sel),
        .out_o(muxOut)
    );

    assign output1 = muxOut;

    // The change pulse is qualified by valid so the first load after reset never flags.
    always_comb begin
        loadData_d   = loadData_q;
        loadSel_d    = loadSel_q;
        loadValid_d  = loadValid_q;
        selChanged_d = 1'b0;
        if (en) begin
            loadData_d   = muxOut;
            loadSel_d    = sel;
            loadValid_d  = 1'b1;
            selChanged_d = loadValid_q && (sel != loadSel_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            loadData_q   <= RESET_VAL;
            loadSel_q    <= SEL_IN1;
            loadValid_q  <= 1'b0;
            selChanged_q <= 1'b0;
        end else begin
            loadData_q   <= loadData_d;
            loadSel_q    <= loadSel_d;
            loadValid_q  <= loadValid_d;
            selChanged_q <= selChanged_d;
        end
    end

    assign output1_q   = loadData_q;
    assign sel_q       = loadSel_q;
    assign valid_q     = loadValid_q;
    assign sel_changed = selChanged_q;

endmodule

// File: tb/tb_mux2_to_1.sv
// Self-checking bench for mux2_to_1: directed literal checks plus randomized traffic
// compared every cycle against a load-history model, on a 32-bit and an 8-bit instance.
module tb_mux2_to_1;

    localparam logic [7:0] RESET_VAL8 = 8'h3C;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sel;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [7:0]  in1_8;
    logic [7:0]  in2_8;

    logic [31:0] out32;
    logic [31:0] out32_q;
    logic        sel32_q;
    logic        valid32_q;
    logic        chg32;
    logic [7:0]  out8;
    logic [7:0]  out8_q;
    logic        sel8_q;
    logic        valid8_q;
    logic        chg8;

    int total = 0;
    int bad   = 0;

    mux2_to_1 dut32 (
        .clk(clk),
        .rst_n(rst_n),
        .input1(in1),
        .input2(in2),
        .sel(sel),
        .en(en),
        .output1(out32),
        .output1_q(out32_q),
        .sel_q(sel32_q),
        .valid_q(valid32_q),
        .sel_changed(chg32)
    );

    mux2_to_1 #(
        .WIDTH(8),
        .RESET_VAL(RESET_VAL8)
    ) dut8 (
        .clk(clk),
        .rst_n(rst_n),
        .input1(in1_8),
        .input2(in2_8),
        .sel(sel),
        .en(en),
        .output1(out8),
        .output1_q(out8_q),
        .sel_q(sel8_q),
        .valid_q(valid8_q),
        .sel_changed(chg8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each instance remembers the history of loads since the last reset.
    bit          modelKnown = 1'b0;
    logic [31:0] expQ32;
    logic [7:0]  expQ8;
    logic        expSel;
    logic        expValid;
    logic        expChg;
    logic        loadHist[$];

    always @(posedge clk) begin
        if (!rst_n) begin
            loadHist.delete();
            expQ32     = 32'd0;
            expQ8      = RESET_VAL8;
            expSel     = 1'b0;
            expValid   = 1'b0;
            expChg     = 1'b0;
            modelKnown = 1'b1;
        end else if (en) begin
            loadHist.push_back(sel);
            expQ32   = (sel == 1'b1) ? in2 : in1;
            expQ8    = (sel == 1'b1) ? in2_8 : in1_8;
            expSel   = sel;
            expValid = (loadHist.size() > 0);
            expChg   = (loadHist.size() >= 2) && (loadHist[loadHist.size()-1] != loadHist[loadHist.size()-2]);
        end else begin
            expChg = 1'b0;
        end
    end

    always @(negedge clk) begin
        checkOutput("cmp_out32", out32, (sel == 1'b1) ? in2 : in1);
        checkOutput("cmp_out8", {24'd0, out8}, {24'd0, (sel == 1'b1) ? in2_8 : in1_8});
        if (modelKnown) begin
            checkOutput("cmp_q32", out32_q, expQ32);
            checkOutput("cmp_selq32", {31'd0, sel32_q}, {31'd0, expSel});
            checkOutput("cmp_valid32", {31'd0, valid32_q}, {31'd0, expValid});
            checkOutput("cmp_chg32", {31'd0, chg32}, {31'd0, expChg});
            checkOutput("cmp_q8", {24'd0, out8_q}, {24'd0, expQ8});
            checkOutput("cmp_selq8", {31'd0, sel8_q}, {31'd0, expSel});
            checkOutput("cmp_valid8", {31'd0, valid8_q}, {31'd0, expValid});
            checkOutput("cmp_chg8", {31'd0, chg8}, {31'd0, expChg});
        end
    end

    // Inputs change 1 time unit after a rising edge and are sampled at the next one.
    task automatic applyStimulus(input logic r, input logic e, input logic s,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [7:0] a8, input logic [7:0] b8);
        @(posedge clk);
        #1;
        rst_n = r;
        en    = e;
        sel   = s;
        in1   = a;
        in2   = b;
        in1_8 = a8;
        in2_8 = b8;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        sel   = 1'b0;
        in1   = 32'd0;
        in2   = 32'd0;
        in1_8 = 8'h00;
        in2_8 = 8'h00;

        applyStimulus(1'b0, 1'b0, 1'b0, 32'd650, 32'd150, 8'hA5, 8'h5A);
        checkOutput("lit_comb_sel0", out32, 32'd650);
        checkOutput("lit_comb8_sel0", {24'd0, out8}, 32'h0000_00A5);
        sel = 1'b1;
        #1;
        checkOutput("lit_comb_sel1", out32, 32'd150);
        checkOutput("lit_comb8_sel1", {24'd0, out8}, 32'h0000_005A);

        applyStimulus(1'b0, 1'b1, 1'b1, 32'd650, 32'd150, 8'hA5, 8'h5A);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'd650, 32'd150, 8'hA5, 8'h5A);
        checkOutput("lit_rst_q", out32_q, 32'd0);
        checkOutput("lit_rst_valid", {31'd0, valid32_q}, 32'd0);
        checkOutput("lit_rst_selq", {31'd0, sel32_q}, 32'd0);
        checkOutput("lit_rst_chg", {31'd0, chg32}, 32'd0);
        checkOutput("lit_rst_q8", {24'd0, out8_q}, 32'h0000_003C);
        checkOutput("lit_rst_comb", out32, 32'd150);

        applyStimulus(1'b1, 1'b1, 1'b0, 32'd650, 32'd150, 8'hA5, 8'h5A);
        checkOutput("lit_rst2_q", out32_q, 32'd0);
        checkOutput("lit_rst2_valid", {31'd0, valid32_q}, 32'd0);

        applyStimulus(1'b1, 1'b1, 1'b1, 32'd650, 32'd150, 8'hA5, 8'h5A);
        checkOutput("lit_load1_q", out32_q, 32'd650);
        checkOutput("lit_load1_valid", {31'd0, valid32_q}, 32'd1);
        checkOutput("lit_load1_chg", {31'd0, chg32}, 32'd0);
        checkOutput("lit_load1_q8", {24'd0, out8_q}, 32'h0000_00A5);

        applyStimulus(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 8'h11, 8'h22);
        checkOutput("lit_load2_q", out32_q, 32'd150);
        checkOutput("lit_load2_selq", {31'd0, sel32_q}, 32'd1);
        checkOutput("lit_load2_chg", {31'd0, chg32}, 32'd1);
        checkOutput("lit_load2_q8", {24'd0, out8_q}, 32'h0000_005A);
        checkOutput("lit_hold_comb", out32, 32'hFFFF_FFFF);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_1234, 8'h11, 8'h22);
        checkOutput("lit_hold_q", out32_q, 32'd150);
        checkOutput("lit_hold_selq", {31'd0, sel32_q}, 32'd1);
        checkOutput("lit_hold_valid", {31'd0, valid32_q}, 32'd1);
        checkOutput("lit_hold_chg", {31'd0, chg32}, 32'd0);
        checkOutput("lit_hold_comb2", out32, 32'h0000_1234);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), $urandom, $urandom,
                          8'($urandom), 8'($urandom));
        end

        applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 8'h00, 8'h00);
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
